// File: rtl/core_pkg.sv
// Shared constants and types for the memory stage (core_mem_stage, load_align_unit).
package core_pkg;

    localparam logic [6:0] OPCODE_LOAD  = 7'h03;
    localparam logic [6:0] OPCODE_STORE = 7'h23;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} mem_state_e;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} mem_size_e;

    // Unsupported funct3 encodings fall back to a word access.
    function automatic mem_size_e access_size(input logic is_store, input logic [2:0] funct3);
        if (is_store) begin
            if (funct3 == F3_B) return SZ_B;
            if (funct3 == F3_H) return SZ_H;
            return SZ_W;
        end
        if (funct3 == F3_B || funct3 == F3_BU) return SZ_B;
        if (funct3 == F3_H || funct3 == F3_HU) return SZ_H;
        return SZ_W;
    endfunction

endpackage

// File: rtl/load_align_unit.sv
// Selects the addressed lane of a load word and sign/zero-extends it.
module load_align_unit import core_pkg::*; (
    input  logic [31:0] rdata_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  offset_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        case (offset_i)
            2'd0:    byte_lane = rdata_i[7:0];
            2'd1:    byte_lane = rdata_i[15:8];
            2'd2:    byte_lane = rdata_i[23:16];
            default: byte_lane = rdata_i[31:24];
        endcase
        half_lane = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        case (funct3_i)
            F3_B:    data_o = {{24{byte_lane[7]}}, byte_lane};
            F3_BU:   data_o = {24'b0, byte_lane};
            F3_H:    data_o = {{16{half_lane[15]}}, half_lane};
            F3_HU:   data_o = {16'b0, half_lane};
            F3_W:    data_o = rdata_i;
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/core_mem_stage.sv
// Pipeline MEM stage: issues data-memory requests, aligns loads, registers writeback.
// Optional misaligned-access trap enabled by defining CORE_MEM_MISALIGN_EN.
module core_mem_stage import core_pkg::*; #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            ex_valid_i,
    input  logic [6:0]      opcode_i,
    input  logic [2:0]      funct3_i,
    input  logic [4:0]      rd_i,
    input  logic [XLEN-1:0] alu_result_i,
    input  logic [XLEN-1:0] store_data_i,
    output logic            mem_stall_o,
    output logic            dmem_req_o,
    output logic            dmem_we_o,
    output logic [XLEN-1:0] dmem_addr_o,
    output logic [3:0]      dmem_be_o,
    output logic [XLEN-1:0] dmem_wdata_o,
    input  logic            dmem_gnt_i,
    input  logic            dmem_rvalid_i,
    input  logic [XLEN-1:0] dmem_rdata_i,
`ifdef CORE_MEM_MISALIGN_EN
    output logic            misalign_o,
`endif
    output logic            wb_valid_o,
    output logic            wb_reg_write_o,
    output logic [4:0]      wb_rd_o,
    output logic [XLEN-1:0] wb_data_o
);

    mem_state_e      state, state_next;
    logic [XLEN-1:0] addr_q, wdata_q, wdata_n, load_data;
    logic [3:0]      be_q, be_n;
    logic            we_q;
    logic [2:0]      funct3_q;
    logic [4:0]      rd_q;
    logic            accept, is_store, is_mem, issue;
    mem_size_e       size_n;
`ifdef CORE_MEM_MISALIGN_EN
    logic            misal;
`endif

    always_comb begin
        is_store = opcode_i == OPCODE_STORE;
        is_mem   = is_store || (opcode_i == OPCODE_LOAD);
        accept   = (state == IDLE) && ex_valid_i;
        size_n   = access_size(is_store, funct3_i);
        case (size_n)
            SZ_B: begin
                be_n    = 4'b0001 << alu_result_i[1:0];
                wdata_n = {4{store_data_i[7:0]}};
            end
            SZ_H: begin
                be_n    = 4'b0011 << {alu_result_i[1], 1'b0};
                wdata_n = {2{store_data_i[15:0]}};
            end
            default: begin
                be_n    = 4'b1111;
                wdata_n = store_data_i;
            end
        endcase
        issue = accept && is_mem;
`ifdef CORE_MEM_MISALIGN_EN
        misal = ((size_n == SZ_H) && alu_result_i[0]) ||
                ((size_n == SZ_W) && (alu_result_i[1:0] != 2'b00));
        issue = issue && !misal;
`endif
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (issue) state_next = REQ;
            REQ:     if (dmem_gnt_i) state_next = we_q ? IDLE : WAIT;
            WAIT:    if (dmem_rvalid_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_next;
    end

    load_align_unit u_load_align (
        .rdata_i  (dmem_rdata_i),
        .funct3_i (funct3_q),
        .offset_i (addr_q[1:0]),
        .data_o   (load_data)
    );

    // Request fields are captured at acceptance so they stay stable while waiting for grant.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q         <= '0;
            wdata_q        <= '0;
            be_q           <= '0;
            we_q           <= 1'b0;
            funct3_q       <= '0;
            rd_q           <= '0;
            wb_valid_o     <= 1'b0;
            wb_reg_write_o <= 1'b0;
            wb_rd_o        <= '0;
            wb_data_o      <= '0;
`ifdef CORE_MEM_MISALIGN_EN
            misalign_o     <= 1'b0;
`endif
        end else begin
            wb_valid_o <= 1'b0;
`ifdef CORE_MEM_MISALIGN_EN
            misalign_o <= 1'b0;
            if (accept && is_mem && misal) begin
                wb_valid_o     <= 1'b1;
                wb_reg_write_o <= 1'b0;
                misalign_o     <= 1'b1;
            end
`endif
            if (issue) begin
                addr_q   <= alu_result_i;
                wdata_q  <= wdata_n;
                be_q     <= be_n;
                we_q     <= is_store;
                funct3_q <= funct3_i;
                rd_q     <= rd_i;
            end
            if (accept && !is_mem) begin
                wb_valid_o     <= 1'b1;
                wb_reg_write_o <= rd_i != 5'd0;
                wb_rd_o        <= rd_i;
                wb_data_o      <= alu_result_i;
            end
            if ((state == REQ) && dmem_gnt_i && we_q) begin
                wb_valid_o     <= 1'b1;
                wb_reg_write_o <= 1'b0;
            end
            if ((state == WAIT) && dmem_rvalid_i) begin
                wb_valid_o     <= 1'b1;
                wb_reg_write_o <= rd_q != 5'd0;
                wb_rd_o        <= rd_q;
                wb_data_o      <= load_data;
            end
        end
    end

    assign mem_stall_o  = state != IDLE;
    assign dmem_req_o   = state == REQ;
    assign dmem_we_o    = we_q;
    assign dmem_be_o    = be_q;
    assign dmem_wdata_o = wdata_q;
    assign dmem_addr_o  = {addr_q[XLEN-1:2], 2'b00};

endmodule

// File: tb/tb_core_mem_stage.sv
// Randomized bench for core_mem_stage with a transaction-level reference model.
// Define CORE_MEM_MISALIGN_EN to exercise the misaligned-access trap.
module tb_core_mem_stage;

    logic        clk = 1'b0;
    logic        rst_i, ex_valid_i;
    logic [6:0]  opcode_i;
    logic [2:0]  funct3_i;
    logic [4:0]  rd_i;
    logic [31:0] alu_result_i, store_data_i;
    logic        mem_stall_o, dmem_req_o, dmem_we_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o;
    logic [3:0]  dmem_be_o;
    logic        dmem_gnt_i, dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;
    logic        wb_valid_o, wb_reg_write_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;
`ifdef CORE_MEM_MISALIGN_EN
    logic        misalign_o;
`endif

    always #5 clk = ~clk;

    core_mem_stage #(.XLEN(32)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .ex_valid_i     (ex_valid_i),
        .opcode_i       (opcode_i),
        .funct3_i       (funct3_i),
        .rd_i           (rd_i),
        .alu_result_i   (alu_result_i),
        .store_data_i   (store_data_i),
        .mem_stall_o    (mem_stall_o),
        .dmem_req_o     (dmem_req_o),
        .dmem_we_o      (dmem_we_o),
        .dmem_addr_o    (dmem_addr_o),
        .dmem_be_o      (dmem_be_o),
        .dmem_wdata_o   (dmem_wdata_o),
        .dmem_gnt_i     (dmem_gnt_i),
        .dmem_rvalid_i  (dmem_rvalid_i),
        .dmem_rdata_i   (dmem_rdata_i),
`ifdef CORE_MEM_MISALIGN_EN
        .misalign_o     (misalign_o),
`endif
        .wb_valid_o     (wb_valid_o),
        .wb_reg_write_o (wb_reg_write_o),
        .wb_rd_o        (wb_rd_o),
        .wb_data_o      (wb_data_o)
    );

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // Expected outputs for the current cycle, maintained by the transaction script.
    logic        e_stall, e_req, e_we, e_wbv, e_wbw, e_mis, e_zero;
    logic [31:0] e_addr, e_wdata, e_data;
    logic [3:0]  e_be;
    logic [4:0]  e_rd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("mem_stall", {31'b0, mem_stall_o}, {31'b0, e_stall});
            chk("dmem_req", {31'b0, dmem_req_o}, {31'b0, e_req});
            chk("wb_valid", {31'b0, wb_valid_o}, {31'b0, e_wbv});
            chk("wb_rd", {27'b0, wb_rd_o}, {27'b0, e_rd});
            chk("wb_data", wb_data_o, e_data);
            if (e_wbv || e_zero)
                chk("wb_reg_write", {31'b0, wb_reg_write_o}, {31'b0, e_wbw});
            if (e_req || e_zero) begin
                chk("dmem_addr", dmem_addr_o, e_addr);
                chk("dmem_we", {31'b0, dmem_we_o}, {31'b0, e_we});
            end
            if ((e_req && e_we) || e_zero) begin
                chk("dmem_be", {28'b0, dmem_be_o}, {28'b0, e_be});
                chk("dmem_wdata", dmem_wdata_o, e_wdata);
            end
`ifdef CORE_MEM_MISALIGN_EN
            chk("misalign", {31'b0, misalign_o}, {31'b0, e_mis});
`endif
        end
    end

    function automatic int unsigned size_of(input bit st, input logic [2:0] f3);
        if (st) return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
        return (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
    endfunction

    function automatic logic [3:0] m_be(input int unsigned sz, input logic [31:0] a);
        if (sz == 1) return 4'(1 << a[1:0]);
        if (sz == 2) return 4'(3 << (2 * a[1]));
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wdata(input int unsigned sz, input logic [31:0] d);
        if (sz == 1) return (d & 32'hFF) * 32'h0101_0101;
        if (sz == 2) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] r);
        logic [31:0] b, h;
        b = (r >> (8 * a[1:0])) & 32'hFF;
        h = (r >> (16 * a[1])) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 128) ? b - 32'd256 : b;
            3'd4:    return b;
            3'd1:    return (h >= 32768) ? h - 32'd65536 : h;
            3'd5:    return h;
            default: return r;
        endcase
    endfunction

`ifdef CORE_MEM_MISALIGN_EN
    function automatic bit m_misal(input int unsigned sz, input logic [31:0] a);
        return ((sz == 2) && a[0]) || ((sz == 4) && (a[1:0] != 2'b00));
    endfunction
`endif

    task automatic tick();
        @(posedge clk);
        #1;
        e_wbv  = 1'b0;
        e_mis  = 1'b0;
        e_zero = 1'b0;
    endtask

    task automatic rand_fields();
        opcode_i     = 7'($urandom);
        funct3_i     = 3'($urandom);
        rd_i         = 5'($urandom);
        alu_result_i = $urandom;
        store_data_i = $urandom;
    endtask

    // Presents one instruction in an IDLE cycle and plays the memory side.
    // Returns in the cycle after the writeback edge (state back in IDLE).
    task automatic do_insn(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                           input logic [31:0] alu, input logic [31:0] sd, input logic [31:0] rdata,
                           input int gnt_wait, input int rv_wait, input bit rst_wait,
                           output logic [31:0] o_addr, output logic [3:0] o_be,
                           output logic [31:0] o_wdata);
        bit st, ld;
        int unsigned sz;
        st = (op == 7'h23);
        ld = (op == 7'h03);
        sz = size_of(st, f3);
        o_addr = '0; o_be = '0; o_wdata = '0;
        ex_valid_i = 1'b1; opcode_i = op; funct3_i = f3; rd_i = rd;
        alu_result_i = alu; store_data_i = sd;
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'($urandom); dmem_rdata_i = $urandom;
        tick();
        if (!(st || ld)) begin
            e_wbv = 1'b1; e_wbw = (rd != 0); e_data = alu; e_rd = rd;
            ex_valid_i = 1'b0;
            return;
        end
`ifdef CORE_MEM_MISALIGN_EN
        if (m_misal(sz, alu)) begin
            e_wbv = 1'b1; e_wbw = 1'b0; e_mis = 1'b1;
            ex_valid_i = 1'b0;
            return;
        end
`endif
        e_stall = 1'b1; e_req = 1'b1; e_we = st;
        e_addr = alu & ~32'h3; e_be = m_be(sz, alu); e_wdata = m_wdata(sz, sd);
        o_addr = dmem_addr_o; o_be = dmem_be_o; o_wdata = dmem_wdata_o;
        for (int k = 1; k <= gnt_wait; k++) begin
            ex_valid_i = 1'b1; rand_fields();
            dmem_rvalid_i = 1'($urandom); dmem_rdata_i = $urandom;
            dmem_gnt_i = (k == gnt_wait);
            tick();
        end
        dmem_gnt_i = 1'b0;
        if (st) begin
            e_stall = 1'b0; e_req = 1'b0; e_wbv = 1'b1; e_wbw = 1'b0;
            ex_valid_i = 1'b0; dmem_rvalid_i = 1'b0;
            return;
        end
        e_req = 1'b0;
        if (rst_wait) begin
            rst_i = 1'b1; ex_valid_i = 1'b0; dmem_rvalid_i = 1'b0;
            tick();
            rst_i = 1'b0;
            e_stall = 1'b0; e_wbw = 1'b0; e_rd = '0; e_data = '0; e_zero = 1'b1;
            e_addr = '0; e_we = 1'b0; e_be = '0; e_wdata = '0;
            dmem_rvalid_i = 1'b1; dmem_rdata_i = rdata;
            tick();
            tick();
            dmem_rvalid_i = 1'b0;
            return;
        end
        for (int j = 1; j <= rv_wait; j++) begin
            ex_valid_i = 1'b1; rand_fields();
            dmem_rvalid_i = (j == rv_wait);
            dmem_rdata_i = (j == rv_wait) ? rdata : $urandom;
            tick();
        end
        e_stall = 1'b0; e_wbv = 1'b1; e_wbw = (rd != 0); e_rd = rd;
        e_data = m_load(f3, alu, rdata);
        ex_valid_i = 1'b0; dmem_rvalid_i = 1'b0;
    endtask

    logic [31:0] oa, ow, r_alu;
    logic [3:0]  ob;
    logic [6:0]  r_op;
    logic [4:0]  r_rd;

    initial begin
        rst_i = 1'b1; ex_valid_i = 1'b0; opcode_i = '0; funct3_i = '0; rd_i = '0;
        alu_result_i = '0; store_data_i = '0;
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
        {e_stall, e_req, e_we, e_wbv, e_wbw, e_mis} = '0;
        e_addr = '0; e_wdata = '0; e_data = '0; e_be = '0; e_rd = '0;
        tick();
        tick();
        e_zero = 1'b1;
        cmp_en = 1'b1;
        chk("reset_stall", {31'b0, mem_stall_o}, 32'd0);
        chk("reset_req", {31'b0, dmem_req_o}, 32'd0);
        chk("reset_wb_valid", {31'b0, wb_valid_o}, 32'd0);
        rst_i = 1'b0;

        do_insn(7'h33, 3'd0, 5'd5, 32'h1234, 32'h0, 32'h0, 1, 1, 1'b0, oa, ob, ow);
        chk("add_wb_valid", {31'b0, wb_valid_o}, 32'd1);
        chk("add_wb_data", wb_data_o, 32'h1234);
        chk("add_wb_rd", {27'b0, wb_rd_o}, 32'd5);

        do_insn(7'h23, 3'd0, 5'd7, 32'h1003, 32'hAB, 32'h0, 3, 1, 1'b0, oa, ob, ow);
        chk("sb_addr", oa, 32'h1000);
        chk("sb_be", {28'b0, ob}, 32'h8);
        chk("sb_wdata", ow, 32'hABAB_ABAB);
        chk("sb_wb_valid", {31'b0, wb_valid_o}, 32'd1);
        chk("sb_wb_reg_write", {31'b0, wb_reg_write_o}, 32'd0);

        do_insn(7'h03, 3'd0, 5'd9, 32'h2001, 32'h0, 32'h0000_8000, 1, 2, 1'b0, oa, ob, ow);
        chk("lb_data", wb_data_o, 32'hFFFF_FF80);
        do_insn(7'h03, 3'd4, 5'd9, 32'h2001, 32'h0, 32'h0000_8000, 2, 1, 1'b0, oa, ob, ow);
        chk("lbu_data", wb_data_o, 32'h0000_0080);

        do_insn(7'h03, 3'd2, 5'd4, 32'h4000, 32'h0, 32'hCAFE_F00D, 1, 3, 1'b0, oa, ob, ow);
        chk("lw_wb_valid", {31'b0, wb_valid_o}, 32'd1);
        chk("lw_data", wb_data_o, 32'hCAFE_F00D);

        do_insn(7'h03, 3'd2, 5'd6, 32'h5000, 32'h0, 32'h1, 1, 1, 1'b1, oa, ob, ow);
        chk("rst_wait_wb_valid", {31'b0, wb_valid_o}, 32'd0);
        chk("rst_wait_stall", {31'b0, mem_stall_o}, 32'd0);

`ifdef CORE_MEM_MISALIGN_EN
        do_insn(7'h03, 3'd2, 5'd3, 32'h3002, 32'h0, 32'h0, 1, 1, 1'b0, oa, ob, ow);
        chk("misal_flag", {31'b0, misalign_o}, 32'd1);
        chk("misal_no_req", {31'b0, dmem_req_o}, 32'd0);
`endif

        for (int n = 0; n < 300; n++) begin
            case ($urandom % 3)
                0: begin
                    r_op = 7'($urandom);
                    if (r_op == 7'h03 || r_op == 7'h23) r_op = 7'h13;
                end
                1:       r_op = 7'h03;
                default: r_op = 7'h23;
            endcase
            r_rd  = ($urandom % 4 == 0) ? 5'd0 : 5'($urandom);
            r_alu = $urandom;
            do_insn(r_op, 3'($urandom), r_rd, r_alu, $urandom, $urandom,
                    $urandom_range(1, 4), $urandom_range(1, 4), 1'b0, oa, ob, ow);
            if ($urandom % 4 == 0) begin
                ex_valid_i = 1'b0;
                dmem_rvalid_i = 1'($urandom);
                tick();
                dmem_rvalid_i = 1'b0;
            end
        end
        tick();
        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
